// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event strobes into long level pulses
// with a guaranteed minimum high time (HOLD_CYCLES) and low time (GAP_CYCLES).
// Events that arrive while a pulse or gap is running are counted in a
// saturating queue and replayed in order; a dropped event sets a sticky flag.
//
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN
//   defined   : trig while HIGH restarts the hold instead of queueing.
//   undefined : every event is queued (default).
//
// state_dbg mirrors the FSM state register (0=IDLE, 1=HIGH, 2=GAP).
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000,
    parameter int CNT_W       = 25,
    parameter int MAX_PEND    = 7,
    parameter int PEND_W      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trig,
    output logic              dout,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  counter_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              overflow_nxt;
    logic              hold_end;
    logic              gap_end;
    logic              has_pend;
    logic              retrig;
    logic              inc;
    logic              dec;

    assign hold_end  = (state == HIGH) && (counter == HOLD_LAST);
    assign gap_end   = (state == GAP)  && (counter == GAP_LAST);
    assign has_pend  = (pending != '0);
    assign state_dbg = state;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    // A trigger during the high phase extends the pulse rather than queueing.
    assign retrig = trig && (state == HIGH);
    assign inc    = trig && (((state == GAP) && !gap_end) || (gap_end && has_pend));
`else
    assign retrig = 1'b0;
    assign inc    = trig && ((state == HIGH) || ((state == GAP) && !gap_end) ||
                             (gap_end && has_pend));
`endif

    // A queued event is consumed whenever a gap ends with work outstanding.
    assign dec = gap_end && has_pend;

    // Next-state and counter logic for the IDLE -> HIGH -> GAP cycle.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        unique case (state)
            IDLE: begin
                counter_nxt = '0;
                if (trig) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (retrig) begin
                    counter_nxt = '0;
                end else if (hold_end) begin
                    state_nxt   = GAP;
                    counter_nxt = '0;
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    counter_nxt = '0;
                    // A trig landing exactly on the gap end starts the next
                    // pulse directly without passing through the queue.
                    if (has_pend || trig) begin
                        state_nxt = HIGH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    counter_nxt = counter + 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
        endcase
    end

    // Saturating queue of pending events; a full queue drops and flags.
    always_comb begin
        pending_nxt  = pending;
        overflow_nxt = overflow;
        if (inc && !dec) begin
            if (pending < PEND_MAX) begin
                pending_nxt = pending + 1'b1;
            end else begin
                overflow_nxt = 1'b1;
            end
        end else if (dec && !inc) begin
            pending_nxt = pending - 1'b1;
        end
    end

    // State, counter, queue and registered outputs; reset aborts any pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            dout     <= (state_nxt == HIGH);
            busy     <= (state_nxt != IDLE);
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: table-driven check of pulse_stretcher with
// HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PEND=3, plus hand-written sequences
// for reset state, asynchronous reset mid-pulse and the retrigger build.
module tb_pulse_stretcher;

    localparam int HOLD   = 4;
    localparam int GAPC   = 2;
    localparam int CNT_W  = 3;
    localparam int MAXP   = 3;
    localparam int PEND_W = 2;

    logic              clock;
    logic              reset;
    logic              trig;
    logic              dout;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    logic [1:0]        state_dbg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              rst;   // pulse reset before applying this row
        logic              trig;
        logic              dout;
        logic              busy;
        logic [PEND_W-1:0] pend;
        logic              ovf;
    } vec_t;

    vec_t vecs[$];

    pulse_stretcher #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAPC),
        .CNT_W      (CNT_W),
        .MAX_PEND   (MAXP),
        .PEND_W     (PEND_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trig     (trig),
        .dout     (dout),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Append n identical rows.
    task automatic add(input logic r, input logic t, input logic d, input logic b,
                       input int p, input logic o, input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.rst  = (k == 0) ? r : 1'b0;
            v.trig = t;
            v.dout = d;
            v.busy = b;
            v.pend = PEND_W'(p);
            v.ovf  = o;
            vecs.push_back(v);
        end
    endtask

    // Drive trig at the falling edge, then check one clock later.
    task automatic step(input logic t);
        @(negedge clock);
        trig = t;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        trig  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset dout", dout, 0);
        check("reset busy", busy, 0);
        check("reset pending", pending, 0);
        check("reset overflow", overflow, 0);
        check("reset state", state_dbg, 0);
        @(negedge clock);
        reset = 1'b1;

`ifndef PULSE_STRETCHER_RETRIGGER_EN
        // Single trig at E0.
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 2);
        // Trig at E0 and E2: one queued event, replayed at E6.
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 2);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 1);
        // Trig held for 6 cycles: queue saturates at 3, two drops, 4 pulses.
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 2, 0, 1);
        add(0, 1, 1, 1, 3, 0, 1);
        add(0, 1, 0, 1, 3, 1, 2);
        add(0, 0, 1, 1, 2, 1, 4);
        add(0, 0, 0, 1, 2, 1, 2);
        add(0, 0, 1, 1, 1, 1, 4);
        add(0, 0, 0, 1, 1, 1, 2);
        add(0, 0, 1, 1, 0, 1, 4);
        add(0, 0, 0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0, 1, 2);
        // Trig on gap end with nothing pending launches the next pulse.
        add(1, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 1);
        // Trig on gap end with one pending: inc and dec cancel.
        add(0, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 2);
        add(0, 1, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 1, 0, 3);
        add(0, 0, 0, 1, 1, 0, 2);
        add(0, 0, 1, 1, 0, 0, 4);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].trig);
            check($sformatf("row%0d dout", i), dout, vecs[i].dout);
            check($sformatf("row%0d busy", i), busy, vecs[i].busy);
            check($sformatf("row%0d pending", i), pending, vecs[i].pend);
            check($sformatf("row%0d overflow", i), overflow, vecs[i].ovf);
        end
`else
        // Retrigger: trig at E0 and E2 holds dout high through E5.
        step(1'b1);
        check("rt E0 dout", dout, 1);
        step(1'b0);
        check("rt E1 dout", dout, 1);
        step(1'b1);
        check("rt E2 dout", dout, 1);
        check("rt E2 pending", pending, 0);
        for (int k = 3; k <= 5; k++) begin
            step(1'b0);
            check($sformatf("rt E%0d dout", k), dout, 1);
            check($sformatf("rt E%0d pending", k), pending, 0);
        end
        step(1'b0);
        check("rt E6 dout", dout, 0);
        check("rt E6 busy", busy, 1);
        step(1'b0);
        check("rt E7 busy", busy, 1);
        step(1'b0);
        check("rt E8 busy", busy, 0);
        check("rt E8 state", state_dbg, 0);
`endif

        // Asynchronous reset mid-pulse with two events queued.
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b1);
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        check("pre-reset pending", pending, 2);
`endif
        check("pre-reset dout", dout, 1);
        trig = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async reset dout", dout, 0);
        check("async reset busy", busy, 0);
        check("async reset pending", pending, 0);
        check("async reset overflow", overflow, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0);
            check($sformatf("post-reset cyc%0d dout", k), dout, 0);
            check($sformatf("post-reset cyc%0d busy", k), busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Counterpart to the debounced edge detector. It converts single-cycle event pulses back into clean, long level pulses of guaranteed minimum high and low time.
- It sits on the consumer side of the GALS producer/consumer path. It drives LEDs and slow-domain request lines from `rising`-style strobes.
- Events that arrive while a pulse is in progress are queued in a saturating counter and replayed in order. Queue overflow is flagged sticky.

Parameters:
- HOLD_CYCLES, 25000000: clocks `dout` stays high per event (0.5 s at 50 MHz); must be >= 1.
- GAP_CYCLES, 2500000: minimum clocks `dout` stays low after each pulse (50 ms); must be >= 1.
- CNT_W, 25: width of the internal cycle counter; must hold max(HOLD_CYCLES, GAP_CYCLES).
- MAX_PEND, 7: maximum queued events; must be >= 1.
- PEND_W, 3: width of `pending`; must hold MAX_PEND.

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears everything immediately).
- trig  input  1  event strobe, sampled each posedge; each high cycle counts as one event.
- dout  output  1  stretched pulse, registered.
- busy  output  1  registered; 1 while in HIGH or GAP.
- pending  output  PEND_W  registered count of queued, not-yet-emitted events.
- overflow  output  1  sticky; set when an event is dropped because the queue is full.

Behaviour:
- Reset (reset==0, async): state=IDLE, counter=0, dout=0, busy=0, pending=0, overflow=0. Reset asserted mid-pulse aborts the pulse at once: dout drops and queued events are discarded.
- States: IDLE, HIGH, GAP. busy=1 exactly when state is HIGH or GAP.
- IDLE: when trig=1 at an edge, go to HIGH, set dout<=1, counter<=0, pending unchanged. Latency from trig to dout is 1 clock.
- HIGH: counter increments each edge. At the edge where counter==HOLD_CYCLES-1, go to GAP, set dout<=0, counter<=0. dout is therefore high for exactly HOLD_CYCLES clocks.
- GAP: counter increments each edge. At the edge where counter==GAP_CYCLES-1 (the "gap end"):
  - if pending>0 or trig=1: go to HIGH, dout<=1, counter<=0;
  - otherwise: go to IDLE.
  - dout is therefore low for at least GAP_CYCLES clocks between pulses.
- Queue accounting, evaluated per edge:
  - inc = trig && (state==HIGH || (state==GAP && !gap_end) || (gap_end && pending>0))
  - dec = gap_end && pending>0
  - inc && dec: pending unchanged.
  - inc only: pending+1 if pending<MAX_PEND; else the event is dropped and overflow<=1.
  - dec only: pending-1.
  - trig at gap end with pending==0: launches the next pulse directly; pending stays 0.
- Consecutive trig-high cycles count as separate events; trig is never edge-detected here.
- overflow clears only on reset.
- N accepted events produce exactly N pulses (N <= MAX_PEND+1 for events arriving within one pulse window).

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined: trig=1 while in HIGH restarts the hold (counter<=0, dout stays 1) instead of queueing, so the pulse extends to HOLD_CYCLES after the last trig. Triggers in GAP still queue as above. pending never increments from HIGH.
- Not defined: behaviour exactly as in Behaviour; every event is queued.

Test Plan:
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PEND=3.
- Single trig pulse at edge E0 -> dout=1 after E0 through E3, dout=0 after E4. busy=1 after E0 through E5, busy=0 after E6. pending stays 0.
- trig at E0 and E2 -> first pulse as above. pending=1 after E2. At E6 pending returns to 0 and dout=1 after E6 through E9. No gap shorter than 2 clocks.
- trig held high for 6 cycles from E0 -> pending reaches 3 at E3. The trigs at E4 and E5 are dropped and overflow=1 and stays 1. Exactly 4 pulses are emitted, separated by 2-clock gaps.
- Pulse in progress with pending=2, then reset driven low asynchronously between edges -> dout, busy, and pending go to 0 immediately, overflow=0. No pulses follow after reset is released.
- trig coincident with the gap-end edge E6 while pending=0 -> HIGH entered at E6, dout=1 after E6, pending remains 0. With pending=1 at E6, pending remains 1 (inc and dec cancel).
- With PULSE_STRETCHER_RETRIGGER_EN defined: trig at E0 and E2 -> dout high continuously from after E0 until E6 (4 clocks after E2), pending=0 throughout, then a 2-clock gap and IDLE.
